// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage sitting directly in front of the control unit.
//   It owns the fetch PC and issues in-order word reads to instruction
//   memory over a valid/ready request channel. Returned words are buffered
//   in a small FIFO tagged with their PC and handed to decode. A taken
//   branch reported by decode redirects the PC, flushes the buffer and
//   marks every word still in flight as stale so it is dropped on arrival.
//
// Parameters
//   RESET_PC  PC loaded on reset
//   DEPTH     buffer entries; also the cap on outstanding + buffered words
//
// Ports
//   clk, rst_n                       clock (rising edge), async active-low reset
//   imem_req_valid/ready, imem_addr  read request channel (word aligned)
//   imem_rsp_valid, imem_rsp_data    in-order read responses
//   instr_valid/ready, instr, instr_pc  buffer head presented to decode
//   PCsrc, ImmOp                     branch decision and offset from decode
//   pc_out                           current fetch PC (trace)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        PCsrc,
  input  logic [31:0] ImmOp,
  output logic [31:0] pc_out
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [31:0]   buf_instr [DEPTH];
  logic [31:0]   buf_pc    [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;

  logic        credit_ok;
  logic        accept;
  logic        redirect;
  logic        req_fire;
  logic        push;
  logic [31:0] target;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (int'(p) == DEPTH - 1) return '0;
    else return p + 1'b1;
  endfunction

  // Every word we may still receive needs a guaranteed buffer slot, so the
  // request credit counts in-flight words (stale ones included) plus the
  // words already buffered.
  assign credit_ok = (int'(outstanding) + int'(count)) < DEPTH;

  assign instr_valid = (count != '0);
  assign accept      = instr_valid & instr_ready;
  assign redirect    = accept & PCsrc;

  // Gating with rst_n keeps the request quiet while reset is held.
  assign imem_req_valid = rst_n & credit_ok & ~redirect;
  assign imem_addr      = fetch_pc;
  assign pc_out         = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // A response lands in the buffer only if it is not stale and the buffer
  // is not being flushed this cycle.
  assign push = imem_rsp_valid & (discard == '0) & ~redirect;

  assign instr    = instr_valid ? buf_instr[rd_ptr] : '0;
  assign instr_pc = instr_valid ? buf_pc[rd_ptr]    : '0;
  assign target   = (instr_pc + ImmOp) & ~32'h3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_instr[i] <= '0;
        buf_pc[i]    <= '0;
      end
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect) begin
        // Everything still in flight after this cycle's response belongs to
        // the old path; no request fires in a redirect cycle.
        fetch_pc <= target;
        rsp_pc   <= target;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        discard  <= outstanding - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (imem_rsp_valid && (discard != '0)) discard <= discard - 1'b1;
        if (push) begin
          buf_instr[wr_ptr] <= imem_rsp_data;
          buf_pc[wr_ptr]    <= rsp_pc;
          wr_ptr            <= ptr_inc(wr_ptr);
          rsp_pc            <= rsp_pc + 32'd4;
        end
        if (accept) rd_ptr <= ptr_inc(rd_ptr);
        count <= count + CW'(push) - CW'(accept);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Drives fetch_unit with a latency-configurable in-order memory and a
//   decode stage that can stall, branch or hold PCsrc high. A queue-based
//   model of the fetch stage (in-flight requests tagged stale on a branch,
//   a buffer of {pc, word}) predicts every output each cycle; directed
//   literal checks pin latency, branch targets, wrap-around and reset.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        PCsrc = 1'b0;
  logic [31:0] ImmOp = '0;
  logic [31:0] pc_out;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .PCsrc(PCsrc), .ImmOp(ImmOp), .pc_out(pc_out)
  );

  typedef struct { logic [31:0] addr; bit stale; int due; } flight_t;
  typedef struct { logic [31:0] pc; logic [31:0] word; } entry_t;

  flight_t     inflight[$];
  entry_t      fifo_q[$];
  logic [31:0] m_fetch_pc;
  int          cycle = 0;
  int          last_due = 0;

  bit          m_req_valid, m_instr_valid, m_redirect;
  logic [31:0] m_instr, m_instr_pc;

  int checks = 0;
  int failures = 0;

  // stimulus knobs
  int lat_min = 1, lat_max = 1;
  bit rand_req_ready = 0, rand_decode = 0, stall_decode = 0, pcsrc_high = 0;

  // armed branch and the literal decode stream expected after it
  bit          br_armed = 0, br_fired = 0;
  logic [31:0] br_pc, br_imm;
  logic [31:0] br_exp[$];
  logic [31:0] br_pend[$];

  // DUT observations pinned against literals
  int          fire_count = 0;
  int          first_fire_cycle = -1, first_valid_cycle = -1;
  logic [31:0] first_fire_addr = '0;
  logic [31:0] accept_log[$];

  // Instruction memory content: a scrambled function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check_val(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", name, cycle, act, exp);
    end
  endtask

  // Model outputs from the current model state and this cycle's inputs.
  task automatic compute_model();
    m_instr_valid = fifo_q.size() > 0;
    m_instr       = m_instr_valid ? fifo_q[0].word : 32'h0;
    m_instr_pc    = m_instr_valid ? fifo_q[0].pc   : 32'h0;
    m_redirect    = m_instr_valid && instr_ready && PCsrc;
    m_req_valid   = rst_n && (inflight.size() + fifo_q.size() < DEPTH) && !m_redirect;
  endtask

  task automatic checkOutput();
    check_val("req_valid", 32'(imem_req_valid), 32'(m_req_valid));
    check_val("imem_addr", imem_addr, m_fetch_pc);
    check_val("pc_out", pc_out, m_fetch_pc);
    check_val("instr_valid", 32'(instr_valid), 32'(m_instr_valid));
    check_val("instr", instr, m_instr);
    check_val("instr_pc", instr_pc, m_instr_pc);
    if (imem_req_valid && imem_req_ready) begin
      fire_count++;
      if (first_fire_cycle < 0) begin
        first_fire_cycle = cycle;
        first_fire_addr  = imem_addr;
      end
    end
    if (instr_valid && first_valid_cycle < 0) first_valid_cycle = cycle;
    if (instr_valid && instr_ready) begin
      accept_log.push_back(instr_pc);
      if (br_pend.size() > 0) check_val("branch_stream", instr_pc, br_pend.pop_front());
    end
  endtask

  // Advance the model across the coming rising edge.
  task automatic step_model();
    bit      accept, fire;
    flight_t r, f;
    int      due;
    accept = m_instr_valid && instr_ready;
    fire   = m_req_valid && imem_req_ready;
    if (accept && !m_redirect) void'(fifo_q.pop_front());
    if (imem_rsp_valid) begin
      r = inflight.pop_front();
      if (!r.stale && !m_redirect) fifo_q.push_back('{pc: r.addr, word: mem_word(r.addr)});
    end
    if (m_redirect) begin
      fifo_q.delete();
      foreach (inflight[i]) inflight[i].stale = 1;
      m_fetch_pc = (m_instr_pc + ImmOp) & ~32'h3;
      if (br_armed) begin
        br_armed = 0;
        br_fired = 1;
        br_pend  = br_exp;
      end
    end
    if (fire) begin
      due = cycle + $urandom_range(lat_min, lat_max);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      f.addr = m_fetch_pc; f.stale = 0; f.due = due;
      inflight.push_back(f);
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
    cycle++;
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    if (inflight.size() > 0 && inflight[0].due <= cycle) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(inflight[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    imem_req_ready = rand_req_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    instr_ready    = stall_decode ? 1'b0 : (rand_decode ? 1'($urandom_range(0, 1)) : 1'b1);
    if (pcsrc_high) begin
      PCsrc = 1'b1; ImmOp = $urandom;
    end else if (br_armed && fifo_q.size() > 0 && fifo_q[0].pc == br_pc) begin
      PCsrc = 1'b1; ImmOp = br_imm;
    end else begin
      PCsrc = 1'b0; ImmOp = $urandom;
    end
    #1;
    compute_model();
    checkOutput();
    step_model();
  endtask

  task automatic run_cycles(input int n);
    repeat (n) applyStimulus();
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; instr_ready = 1'b0; PCsrc = 1'b0;
    #1;
    fifo_q.delete(); inflight.delete();
    m_fetch_pc = RESET_PC; last_due = cycle;
    br_armed = 0; br_pend.delete();
    compute_model();
    checkOutput();
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Arm a branch at pc, wait (bounded) for it to be taken, then let the
  // expected post-branch stream drain.
  task automatic do_branch(input logic [31:0] pc, input logic [31:0] imm, input int n_after);
    br_pc = pc; br_imm = imm; br_armed = 1; br_fired = 0;
    for (int i = 0; i < 60 && !br_fired; i++) applyStimulus();
    check_val("branch_fired", 32'(br_fired), 32'd1);
    run_cycles(n_after);
    check_val("branch_stream_done", br_pend.size(), 32'd0);
  endtask

  initial begin
    // reset values, sequential fetch at latency 1
    do_reset(2);
    check_val("reset_req_valid", 32'(imem_req_valid), 32'd0);
    check_val("reset_addr", imem_addr, RESET_PC);
    first_fire_cycle = -1; first_valid_cycle = -1; accept_log.delete();
    run_cycles(12);
    check_val("fire_to_valid", first_valid_cycle - first_fire_cycle, 32'd2);
    check_val("first_fire_addr", first_fire_addr, 32'h0);
    check_val("accepts_ge3", 32'(accept_log.size() >= 3), 32'd1);
    if (accept_log.size() >= 3) begin
      check_val("seq_pc0", accept_log[0], 32'h0);
      check_val("seq_pc1", accept_log[1], 32'h4);
      check_val("seq_pc2", accept_log[2], 32'h8);
    end

    // decode stall: only DEPTH requests go out
    do_reset(1);
    stall_decode = 1; fire_count = 0;
    run_cycles(10);
    check_val("stall_fires", fire_count, DEPTH);
    check_val("stall_req_valid", 32'(imem_req_valid), 32'd0);
    stall_decode = 0;
    run_cycles(10);

    // forward branch with a word in flight
    do_reset(1);
    br_exp = '{32'h28, 32'h2C};
    do_branch(32'h8, 32'h20, 8);

    // backward branch, misaligned offset, wrap past 2^32
    do_reset(1);
    br_exp = '{32'h8, 32'hC};
    do_branch(32'h10, 32'hFFFF_FFF8, 4);
    br_exp = '{32'h38, 32'h3C};
    do_branch(32'h18, 32'h22, 4);
    br_exp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    do_branch(32'h40, 32'hFFFF_FFB8, 10);

    // random memory ready, latency 1-3, random decode ready
    do_reset(1);
    rand_req_ready = 1; rand_decode = 1; lat_min = 1; lat_max = 3;
    run_cycles(300);
    rand_req_ready = 0; rand_decode = 0; lat_max = 1;
    run_cycles(15);

    // reset with the buffer full
    stall_decode = 1;
    run_cycles(6);
    check_val("full_before_reset", 32'(instr_valid), 32'd1);
    do_reset(2);
    check_val("reset_clears_valid", 32'(instr_valid), 32'd0);
    stall_decode = 0; first_fire_cycle = -1;
    run_cycles(6);
    check_val("refetch_addr", first_fire_addr, RESET_PC);

    // PCsrc held high while decode stalls: no redirect
    do_reset(1);
    pcsrc_high = 1; stall_decode = 1;
    run_cycles(8);
    check_val("pcsrc_stall_pc_out", pc_out, 32'h8);
    check_val("pcsrc_stall_instr_pc", instr_pc, 32'h0);
    pcsrc_high = 0; stall_decode = 0;
    run_cycles(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog cycle=%0d got=timeout expected=finish", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
